spi_slave_ctrl: RTL and testbench

//  SPI responder (slave), mode 0 (CPOL=0, CPHA=0), MSB first. Pairs with the team's SPI master controller.

---
 rtl/spi_slave_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_ctrl.sv
// -----------------------------------------------------------------------------
// spi_slave_ctrl
//   SPI responder, mode 0 (CPOL=0, CPHA=0), MSB first. The SPI pins are
//   oversampled in the clk domain. mosi is deserialised into words for the
//   local client. A single-entry holding register feeds words onto miso.
//
// Ports
//   clk, rst          system clock (>= 8x sck) and asynchronous active-high reset
//   sck, cs_n, mosi   SPI pins from the master (asynchronous to clk)
//   miso, miso_oe     SPI data back to the master and its output enable
//   tx_data/valid     next word to return; accepted when tx_valid && tx_ready
//   tx_ready          holding register empty
//   rx_data/valid     last complete received word and its one-clk strobe
//   underrun          one-clk pulse when FILL_BYTE is loaded for lack of data
//   frame_active      chip select seen low (synchronised)
//   byte_count        words completed in the current/last frame, saturating
// -----------------------------------------------------------------------------
module spi_slave_ctrl #(
    parameter int unsigned          DATA_W      = 8,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0]    FILL_BYTE   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              underrun,
    output logic              frame_active,
    output logic [7:0]        byte_count
);

    localparam int unsigned       CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Synchronisers plus one extra flop per pin for edge detection
    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_prev_q, cs_prev_q;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_fall, cs_rise;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic              active_q, active_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              load;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise =  sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s &  sck_prev_q;
    assign cs_fall  = ~cs_s  &  cs_prev_q;
    assign cs_rise  =  cs_s  & ~cs_prev_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        oe_d        = oe_q;
        active_d    = active_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load        = 1'b0;

        if (cs_rise) begin
            // End of frame wins over any simultaneous sck edge; partial word is dropped
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            rx_sh_d   = '0;
            tx_sh_d   = '0;
            oe_d      = 1'b0;
            active_d  = 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (cs_fall) begin
                state_d    = ST_SHIFT;
                load       = 1'b1;
                bit_cnt_d  = '0;
                byte_cnt_d = '0;
                oe_d       = 1'b1;
                active_d   = 1'b1;
            end
        end else if (sck_rise) begin
            rx_sh_d = {rx_sh_q[DATA_W-2:0], mosi_s};
            if (bit_cnt_q == LAST_BIT) begin
                rx_data_d  = rx_sh_d;
                rx_valid_d = 1'b1;
                bit_cnt_d  = '0;
                if (byte_cnt_q != 8'hFF) begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end else if (sck_fall) begin
            // bit_cnt of zero on a falling edge means a word just completed
            if (bit_cnt_q == '0) begin
                load = 1'b1;
            end else begin
                tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
            end
        end

        if (load) begin
            if (hold_full_q) begin
                tx_sh_d     = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_sh_d    = FILL_BYTE;
                underrun_d = 1'b1;
            end
        end

        // A write is only taken while empty, so it never collides with a load that drains the register
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        miso_d = oe_d & tx_sh_d[DATA_W-1];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            active_q    <= 1'b0;
            // NOTE: the holding data register is reset too; it is a single word, not a memory array.
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
            state_q     <= state_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            active_q    <= active_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign miso         = miso_q;
    assign miso_oe      = oe_q;
    assign tx_ready     = ~hold_full_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign underrun     = underrun_q;
    assign frame_active = active_q;
    assign byte_count   = byte_cnt_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_ctrl
//   Drives spi_slave_ctrl as a mode-0 SPI master plus a byte-wide host.
//   The reference model is a one-entry holding queue: each word load pops it
//   or yields FILL with an underrun. Received-word expectations are queued as
//   the master shifts them out. A separate monitor pops them on every rx_valid.
// -----------------------------------------------------------------------------
module tb_spi_slave_ctrl;

    localparam int         DW   = 8;
    localparam int         SS   = 2;
    localparam int         HALF = 6;     // clk cycles per sck half period
    localparam logic [7:0] FILL = 8'h00;

    logic       clk;
    logic       rst;
    logic       sck, cs_n, mosi;
    logic       miso, miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, underrun, frame_active;
    logic [7:0] byte_count;

    spi_slave_ctrl #(.DATA_W(DW), .SYNC_STAGES(SS), .FILL_BYTE(FILL)) dut (
        .clk          (clk),
        .rst          (rst),
        .sck          (sck),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .miso_oe      (miso_oe),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .underrun     (underrun),
        .frame_active (frame_active),
        .byte_count   (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_miso_q[$];
    logic [7:0] hold_m[$];
    int         exp_underrun = 0;
    int         seen_underrun = 0;
    int         seen_rx = 0;
    logic [7:0] mosi_buf[0:259];
    bit         wr_en[0:259];
    logic [7:0] wr_val[0:259];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rx_valid pulse consumes one expected word
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            seen_rx++;
            if (exp_rx_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rx_unexpected: got word %0h expected no rx_valid", rx_data);
            end else begin
                check("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
            end
        end
        if (underrun === 1'b1) seen_underrun++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Reference model: a word load takes the held word, or FILL with an underrun
    task automatic model_load();
        if (hold_m.size() > 0) begin
            exp_miso_q.push_back(hold_m.pop_front());
        end else begin
            exp_miso_q.push_back(FILL);
            exp_underrun++;
        end
    endtask

    // One-clk host write; accepted only while the holding register is empty
    task automatic host_write(input logic [7:0] v);
        check("tx_ready_before_write", 32'(tx_ready), 32'(hold_m.size() == 0));
        tx_data  = v;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        if (hold_m.size() == 0) hold_m.push_back(v);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_miso"},         32'(miso),         32'd0);
        check({tag, "_miso_oe"},      32'(miso_oe),      32'd0);
        check({tag, "_tx_ready"},     32'(tx_ready),     32'd1);
        check({tag, "_rx_data"},      32'(rx_data),      32'd0);
        check({tag, "_rx_valid"},     32'(rx_valid),     32'd0);
        check({tag, "_underrun"},     32'(underrun),     32'd0);
        check({tag, "_frame_active"}, 32'(frame_active), 32'd0);
        check({tag, "_byte_count"},   32'(byte_count),   32'd0);
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 260; i++) begin
            wr_en[i]  = 1'b0;
            wr_val[i] = 8'h00;
        end
    endtask

    // Mode-0 master frame of n words. abort_after > 0 ends the frame after that
    // many sck rises, by cs_n or (abort_rst) by a reset pulse. wr_at_fall puts a
    // host write in the very clk the slave loads its first word.
    task automatic spi_frame(input int n, input int abort_after, input bit abort_rst,
                             input bit wr_at_fall, input logic [7:0] wr_fall_val);
        int         w, b, rises, completed;
        logic [7:0] got;
        bit         stop;
        rises = 0;
        got   = '0;
        stop  = 1'b0;
        mosi  = mosi_buf[0][DW-1];
        cs_n  = 1'b0;
        if (wr_at_fall) begin
            repeat (SS) @(negedge clk);
            model_load();
            host_write(wr_fall_val);
            repeat (HALF - SS - 1) @(negedge clk);
        end else begin
            model_load();
            repeat (HALF) @(negedge clk);
        end
        check("frame_active_in_frame", 32'(frame_active), 32'd1);
        check("miso_oe_in_frame",      32'(miso_oe),      32'd1);

        for (int i = 0; i < n * DW && !stop; i++) begin
            w   = i / DW;
            b   = DW - 1 - (i % DW);
            got = {got[DW-2:0], miso};
            sck = 1'b1;
            rises++;
            if (b == 0) begin
                exp_rx_q.push_back(mosi_buf[w]);
                check("miso_word", 32'(got), 32'(exp_miso_q.pop_front()));
            end
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
            if ((w == n - 1 && b == 0) || rises == abort_after) begin
                stop = 1'b1;
                if (abort_rst) begin
                    rst  = 1'b1;
                    cs_n = 1'b1;
                    @(negedge clk);
                    check_reset("rst_mid_word");
                    hold_m.delete();
                    repeat (2) @(negedge clk);
                    rst = 1'b0;
                end else begin
                    // cs_n rises with the last sck fall, so no extra word is loaded
                    cs_n = 1'b1;
                end
            end else begin
                if (b > 0) begin
                    mosi = mosi_buf[w][b-1];
                end else begin
                    mosi = mosi_buf[w+1][DW-1];
                    model_load();
                end
                if (b == DW / 2 && wr_en[w]) begin
                    host_write(wr_val[w]);
                    repeat (HALF - 1) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
            end
        end
        exp_miso_q.delete();

        repeat (SS + 1) @(negedge clk);
        check("miso_oe_after_frame",      32'(miso_oe),      32'd0);
        check("frame_active_after_frame", 32'(frame_active), 32'd0);
        check("miso_after_frame",         32'(miso),         32'd0);
        repeat (4) @(negedge clk);
        completed = abort_rst ? 0 : rises / DW;
        check("byte_count", 32'(byte_count), 32'((completed > 255) ? 255 : completed));
        check("rx_words_outstanding", 32'(exp_rx_q.size()), 32'd0);
        check("underrun_count", 32'(seen_underrun), 32'(exp_underrun));
        check("tx_ready_after_frame", 32'(tx_ready), 32'(hold_m.size() == 0));
    endtask

    int u0, r0;

    initial begin
        rst      = 1'b1;
        sck      = 1'b0;
        cs_n     = 1'b1;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        clear_plan();
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: preloaded A5 returned while 3C is received
        host_write(8'hA5);
        mosi_buf[0] = 8'h3C;
        r0 = seen_rx;
        spi_frame(1, 0, 1'b0, 1'b0, 8'h00);
        check("t1_rx_pulses", 32'(seen_rx - r0), 32'd1);
        check("t1_rx_data", 32'(rx_data), 32'h3C);

        // 2: 11 preloaded, 22 written during word 0, nothing for word 2
        clear_plan();
        host_write(8'h11);
        for (int i = 0; i < 3; i++) mosi_buf[i] = 8'($urandom);
        wr_en[0]  = 1'b1;
        wr_val[0] = 8'h22;
        u0 = seen_underrun;
        spi_frame(3, 0, 1'b0, 1'b0, 8'h00);
        check("t2_underruns", 32'(seen_underrun - u0), 32'd1);

        // 3: abort after 5 rises, then C3 must arrive intact
        clear_plan();
        mosi_buf[0] = 8'($urandom);
        r0 = seen_rx;
        spi_frame(1, 5, 1'b0, 1'b0, 8'h00);
        check("t3_no_rx_on_abort", 32'(seen_rx - r0), 32'd0);
        mosi_buf[0] = 8'hC3;
        spi_frame(1, 0, 1'b0, 1'b0, 8'h00);
        check("t3_rx_data", 32'(rx_data), 32'hC3);

        // 4: write in the same clk as the first load of an empty register
        clear_plan();
        mosi_buf[0] = 8'($urandom);
        mosi_buf[1] = 8'($urandom);
        u0 = seen_underrun;
        spi_frame(2, 0, 1'b0, 1'b1, 8'h55);
        check("t4_underruns", 32'(seen_underrun - u0), 32'd1);

        // Random frames with stray idle sck pulses and random host writes
        for (int f = 0; f < 6; f++) begin
            int n;
            clear_plan();
            n = int'($urandom_range(4, 1));
            for (int i = 0; i < n; i++) begin
                mosi_buf[i] = 8'($urandom);
                wr_en[i]    = ($urandom_range(99) < 60);
                wr_val[i]   = 8'($urandom);
            end
            sck = 1'b1;
            repeat (3) @(negedge clk);
            sck = 1'b0;
            repeat (3) @(negedge clk);
            if ($urandom_range(1) == 1) host_write(8'($urandom));
            spi_frame(n, 0, 1'b0, 1'b0, 8'h00);
        end

        // 5: 260-word frame, byte_count saturates
        clear_plan();
        for (int i = 0; i < 260; i++) begin
            mosi_buf[i] = 8'($urandom);
            wr_en[i]    = ($urandom_range(99) < 50);
            wr_val[i]   = 8'($urandom);
        end
        r0 = seen_rx;
        spi_frame(260, 0, 1'b0, 1'b0, 8'h00);
        check("t5_rx_pulses", 32'(seen_rx - r0), 32'd260);

        // 6: reset mid-word, then 96 received intact
        clear_plan();
        mosi_buf[0] = 8'($urandom);
        spi_frame(1, 3, 1'b1, 1'b0, 8'h00);
        mosi_buf[0] = 8'h96;
        spi_frame(1, 0, 1'b0, 1'b0, 8'h00);
        check("t6_rx_data", 32'(rx_data), 32'h96);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
